// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants and state encoding for the stopwatch sequencing controller.
// Stage width, enable levels and the controller state set live here.
package stopwatch_ctrl_pkg;

  localparam int         BCD_BIT_WIDTH = 4;
  localparam logic       ENABLED       = 1'b1;
  localparam logic       DISABLED      = 1'b0;
  localparam logic [3:0] BCD_ZERO      = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler producing a registered one-cycle tick every TICK_DIV cycles while running.
// Holds its count when neither run nor clr is asserted, so a resume keeps its phase.
module stopwatch_ctrl_tick_gen #(
  parameter int TICK_DIV = 1000000,
  parameter int DIV_W    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_run) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button FSM, tick gating, lap display latch and
// sticky chain-overflow flag in front of a cascaded BCD counter chain.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000,
  parameter int DIV_W    = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              btn_start_stop,
  input  logic                              btn_lap_reset,
  input  logic                              chain_carry,
  input  logic [DIGITS*BCD_BIT_WIDTH-1:0]   digits_live,
  output logic                              cnt_increase,
  output logic                              cnt_load_default,
  output logic [DIGITS*BCD_BIT_WIDTH-1:0]   digits_disp,
  output logic                              running,
  output logic                              lap_active,
  output logic                              overflow,
  output logic [2:0]                        dbg_state
);

  state_t                            r_state;
  state_t                            w_next;
  logic                              w_tick;
  logic                              w_run_st;
  logic                              w_clear;
  logic                              w_idle;
  logic [DIGITS*BCD_BIT_WIDTH-1:0]   r_disp;
  logic                              r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // start_stop is tested first everywhere, so it wins over a simultaneous lap_reset.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (btn_start_stop)     w_next = ST_RUN;
        else if (btn_lap_reset) w_next = ST_CLEAR;
      end
      ST_RUN: begin
        if (btn_start_stop)     w_next = ST_PAUSE;
        else if (btn_lap_reset) w_next = ST_LAP;
      end
      ST_LAP: begin
        if (btn_start_stop)     w_next = ST_PAUSE;
        else if (btn_lap_reset) w_next = ST_RUN;
      end
      ST_PAUSE: begin
        if (btn_start_stop)     w_next = ST_RUN;
        else if (btn_lap_reset) w_next = ST_CLEAR;
      end
      ST_CLEAR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_run_st = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_clear  = (r_state == ST_CLEAR);
  assign w_idle   = (r_state == ST_IDLE);

  stopwatch_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_run_st),
    .i_clr  (w_idle | w_clear),
    .o_tick (w_tick)
  );

  // Stages reload only when increase and load_default coincide, hence both in CLEAR.
  assign cnt_increase     = (w_tick & w_run_st) | w_clear;
  assign cnt_load_default = w_clear;

  // The entry edge into LAP still samples live digits; only LAP itself freezes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_disp <= {DIGITS{BCD_ZERO}};
    else if (r_state != ST_LAP) r_disp <= digits_live;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ovf <= DISABLED;
    else if (w_clear)
      r_ovf <= DISABLED;
    else if (cnt_increase && !cnt_load_default && chain_carry)
      r_ovf <= ENABLED;
  end

  assign digits_disp = r_disp;
  assign running     = w_run_st;
  assign lap_active  = (r_state == ST_LAP);
  assign overflow    = r_ovf;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, DIGITS=2, driving a behavioural BCD chain.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       chain_carry;
  logic [7:0] digits_live;
  logic [7:0] digits_disp;
  logic       cnt_increase;
  logic       cnt_load_default;
  logic       running;
  logic       lap_active;
  logic       overflow;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        ss;
    logic        lr;
    int          n;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[11];

  // clock / reset
  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIGITS   (2),
    .TICK_DIV (4),
    .DIV_W    (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_start_stop   (btn_ss),
    .btn_lap_reset    (btn_lr),
    .chain_carry      (chain_carry),
    .digits_live      (digits_live),
    .cnt_increase     (cnt_increase),
    .cnt_load_default (cnt_load_default),
    .digits_disp      (digits_disp),
    .running          (running),
    .lap_active       (lap_active),
    .overflow         (overflow),
    .dbg_state        (dbg_state)
  );

  // behavioural two-digit BCD up-counter chain, default value 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (r[7:4] == 4'd9) r[7:4] = 4'd0;
      else                r[7:4] = r[7:4] + 4'd1;
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)                                digits_live <= 8'h00;
    else if (cnt_increase && cnt_load_default) digits_live <= 8'h00;
    else if (cnt_increase)                   digits_live <= bcd_inc(digits_live);
  end

  assign chain_carry = cnt_increase & (digits_live == 8'h99);

  function automatic logic [15:0] ex(input logic [2:0] st, input logic inc, input logic ld,
                                     input logic run, input logic lap, input logic ovf,
                                     input logic [7:0] d);
    return {st, inc, ld, run, lap, ovf, d};
  endfunction

  function automatic logic [15:0] obs();
    return {dbg_state, cnt_increase, cnt_load_default, running, lap_active, overflow, digits_disp};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: buttons are held across one rising edge, outputs sampled on the next falling edge
  task automatic cyc(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_live(input logic [7:0] v, input int budget, input string name);
    int k;
    k = 0;
    while (digits_live !== v && k < budget) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    checks++;
    if (digits_live !== v) begin
      failures++;
      $display("FAIL %s: timeout, live %h required %h", name, digits_live, v);
    end
  endtask

  task automatic wait_inc(input int budget, input string name);
    int k;
    k = 0;
    while (cnt_increase !== 1'b1 && k < budget) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    checks++;
    if (cnt_increase !== 1'b1) begin
      failures++;
      $display("FAIL %s: timeout, cnt_increase %b required 1", name, cnt_increase);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    logic [7:0]  pre;

    // start pulse at cycle 0: ticks at 4, 8, 12; display trails live by one cycle
    tbl[0]  = '{1'b1, 1'b0, 1, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)};
    tbl[1]  = '{1'b0, 1'b0, 3, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)};
    tbl[2]  = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)};
    tbl[3]  = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)};
    tbl[4]  = '{1'b0, 1'b0, 2, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01)};
    tbl[5]  = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01)};
    tbl[6]  = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01)};
    tbl[7]  = '{1'b0, 1'b0, 2, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02)};
    tbl[8]  = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02)};
    tbl[9]  = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02)};
    tbl[10] = '{1'b0, 1'b0, 1, ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03)};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", obs(), 16'h0000);
    rst = 1'b1;
    @(negedge clk);

    // tick timing table
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        exp_q.push_back(tbl[i].exp);
        cyc((j == 0) ? tbl[i].ss : 1'b0, (j == 0) ? tbl[i].lr : 1'b0);
        e = exp_q.pop_front();
        chk($sformatf("tick_vec%0d_%0d", i, j), obs(), e);
      end
    end

    // overflow at 99 -> 00, sticky, then clear from PAUSE at 37
    do_reset();
    cyc(1'b1, 1'b0);
    wait_live(8'h99, 500, "reach_99");
    chk("ovf_before_wrap", {15'd0, overflow}, 16'd0);
    wait_inc(8, "wrap_tick");
    cyc(1'b0, 1'b0);
    chk("ovf_set", obs(), ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99));
    cyc(1'b0, 1'b0);
    chk("wrap_disp", obs(), ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00));
    wait_live(8'h37, 200, "reach_37");
    chk("ovf_sticky", {15'd0, overflow}, 16'd1);
    cyc(1'b1, 1'b0);
    chk("pause_at_37", obs(), ex(ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h37));
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0);
    chk("pause_hold", obs(), ex(ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h37));
    cyc(1'b0, 1'b1);
    chk("clear_cycle", obs(), ex(ST_CLEAR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h37));
    cyc(1'b0, 1'b0);
    chk("after_clear", obs(), ex(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h37));
    cyc(1'b0, 1'b0);
    chk("cleared_disp", obs(), ex(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    // both buttons together: start_stop wins in RUN and in PAUSE
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("both_in_run", obs(), ex(ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    cyc(1'b1, 1'b1);
    chk("both_in_pause", obs(), ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));

    // lap freeze and release
    do_reset();
    cyc(1'b1, 1'b0);
    wait_live(8'h05, 40, "reach_05");
    cyc(1'b0, 1'b1);
    chk("lap_enter", obs(), ex(ST_LAP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05));
    wait_live(8'h07, 20, "reach_07");
    cyc(1'b0, 1'b0);
    chk("lap_hold", {8'd0, digits_disp}, 16'h0005);
    chk("lap_flag", {14'd0, running, lap_active}, 16'd3);
    cyc(1'b0, 1'b1);
    chk("lap_release", {dbg_state, lap_active, 4'd0, digits_disp},
        {ST_RUN, 1'b0, 4'd0, 8'h05});
    pre = digits_live;
    cyc(1'b0, 1'b0);
    chk("lap_track", {8'd0, digits_disp}, {8'd0, pre});

    // pause after two prescaler counts keeps phase across resume
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("phase_pause", obs(), ex(ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0);
      chk($sformatf("pause_no_inc%0d", k), {15'd0, cnt_increase}, 16'd0);
    end
    cyc(1'b1, 1'b0);
    chk("resume_c0", obs(), ex(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
    cyc(1'b0, 1'b0);
    chk("resume_c1", {15'd0, cnt_increase}, 16'd0);
    cyc(1'b0, 1'b0);
    chk("resume_c2_tick", {15'd0, cnt_increase}, 16'd1);

    // asynchronous reset mid-run, then restart timing
    do_reset();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0);
    chk("pre_async_disp", {8'd0, digits_disp}, 16'h0002);
    #2 rst = 1'b0;
    #1 chk("async_reset_now", obs(), 16'h0000);
    #9 rst = 1'b1;
    @(negedge clk);
    chk("after_async", obs(), 16'h0000);
    cyc(1'b1, 1'b0);
    chk("restart_c0", {15'd0, cnt_increase}, 16'd0);
    for (int k = 1; k < 4; k++) begin
      cyc(1'b0, 1'b0);
      chk($sformatf("restart_c%0d", k), {15'd0, cnt_increase}, 16'd0);
    end
    cyc(1'b0, 1'b0);
    chk("restart_tick", {15'd0, cnt_increase}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
